// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: boxcar decimator (sum of 2^DECIM_LOG2 samples, arithmetic
// shift), saturation to OUT_W bits, and a small output FIFO with valid/ready.
// Build option: define FIR_DECIM_ROUND_EN for round-half-up before the shift;
// left undefined, the shift truncates toward minus infinity.
module fir_decim_fifo #(
   parameter int unsigned IN_W       = 16,
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned DECIM_LOG2 = 2,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       y_in,
   input  logic                  y_valid,
   output logic [OUT_W-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DEPTH_LOG2:0]   fill,
   output logic                  sat,
   output logic                  ovf
);

   localparam int unsigned DECIM = 1 << DECIM_LOG2;
   localparam int unsigned ACC_W = IN_W + DECIM_LOG2;
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   localparam logic [PH_W-1:0]         PH_LAST = PH_W'(DECIM - 1);
   localparam logic [DEPTH_LOG2:0]     FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic signed [SUM_W-1:0] QMAX = SUM_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] QMIN = SUM_W'(-(1 << (OUT_W - 1)));
`ifdef FIR_DECIM_ROUND_EN
   localparam logic signed [SUM_W-1:0] RND = SUM_W'(DECIM / 2);
`endif

   logic signed [ACC_W-1:0]  acc;
   logic [PH_W-1:0]          phase;
   logic [OUT_W-1:0]         res;
   logic                     res_v;
   logic [OUT_W-1:0]         mem [DEPTH];
   logic [DEPTH_LOG2-1:0]    wptr;
   logic [DEPTH_LOG2-1:0]    rptr;

   logic                     last_c;
   logic signed [SUM_W-1:0]  sum_c;
   logic signed [SUM_W-1:0]  q_c;
   logic [OUT_W-1:0]         res_c;
   logic                     sat_c;
   logic                     full_c;
   logic                     rd_c;
   logic                     wr_c;
   logic [DEPTH_LOG2:0]      fill_nxt_c;

   // Group sum, shift and saturation of the sample closing the current group
   always_comb begin
      last_c = (phase == PH_LAST);
      sum_c  = SUM_W'(acc) + SUM_W'($signed(y_in));
`ifdef FIR_DECIM_ROUND_EN
      sum_c  = sum_c + RND;
`endif
      q_c    = sum_c >>> DECIM_LOG2;
      res_c  = OUT_W'(q_c);
      sat_c  = 1'b0;
      if (q_c > QMAX) begin
         res_c = OUT_W'(QMAX);
         sat_c = 1'b1;
      end else if (q_c < QMIN) begin
         res_c = OUT_W'(QMIN);
         sat_c = 1'b1;
      end
   end

   // FIFO handshake: a full FIFO still takes a write when a read frees a slot
   always_comb begin
      full_c     = (fill == FULL_LVL);
      rd_c       = m_valid & m_ready;
      wr_c       = res_v & (~full_c | rd_c);
      fill_nxt_c = fill;
      case ({wr_c, rd_c})
         2'b10:   fill_nxt_c = fill + 1'b1;
         2'b01:   fill_nxt_c = fill - 1'b1;
         default: fill_nxt_c = fill;
      endcase
   end

   assign m_data = m_valid ? mem[rptr] : '0;

   // Accumulate valid samples; close the group into the result register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         phase <= '0;
         res   <= '0;
         res_v <= 1'b0;
         sat   <= 1'b0;
      end else begin
         res_v <= 1'b0;
         sat   <= 1'b0;
         if (y_valid) begin
            if (last_c) begin
               acc   <= '0;
               phase <= '0;
               res   <= res_c;
               res_v <= 1'b1;
               sat   <= sat_c;
            end else begin
               acc   <= ACC_W'(sum_c);
               phase <= phase + 1'b1;
            end
         end
      end
   end

   // FIFO storage (no reset needed, head is masked while empty)
   always_ff @(posedge clk) begin
      if (wr_c) mem[wptr] <= res;
   end

   // FIFO pointers, occupancy, valid flag and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         fill    <= '0;
         m_valid <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (wr_c) wptr <= wptr + 1'b1;
         if (rd_c) rptr <= rptr + 1'b1;
         if (res_v && !wr_c) ovf <= 1'b1;
         fill    <= fill_nxt_c;
         m_valid <= (fill_nxt_c != '0);
      end
   end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Testbench for fir_decim_fifo: directed group table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fir_decim_fifo;

   localparam int IN_W       = 16;
   localparam int OUT_W      = 8;
   localparam int DECIM_LOG2 = 2;
   localparam int DEPTH_LOG2 = 3;
   localparam int DECIM      = 1 << DECIM_LOG2;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int OMAX       = (1 << (OUT_W - 1)) - 1;
   localparam int OMIN       = -(1 << (OUT_W - 1));

`ifdef FIR_DECIM_ROUND_EN
   localparam int EXP_30 = 8;
   localparam int EXP_M6 = -1;
`else
   localparam int EXP_30 = 7;
   localparam int EXP_M6 = -2;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [IN_W-1:0]       y_in;
   logic                  y_valid;
   logic [OUT_W-1:0]      m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DEPTH_LOG2:0]   fill;
   logic                  sat;
   logic                  ovf;

   fir_decim_fifo #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DECIM_LOG2(DECIM_LOG2), .DEPTH_LOG2(DEPTH_LOG2)
   ) dut (
      .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .fill(fill), .sat(sat), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int grp[$];
   int fq[$];
   int pend;
   bit pend_v;
   bit x_sat;
   bit x_ovf;

   typedef struct {
      int s[4];
      int exp_data;
      bit exp_sat;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string name, input logic signed [31:0] act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // mean of a group by floor division (optionally half-up), then clamp
   function automatic int avg_sat(input longint s, output bit clamped);
      longint q;
`ifdef FIR_DECIM_ROUND_EN
      s = s + DECIM / 2;
`endif
      q = s / DECIM;
      if ((s % DECIM) != 0 && s < 0) q = q - 1;
      clamped = 1'b0;
      if (q > OMAX) begin
         q = OMAX;
         clamped = 1'b1;
      end else if (q < OMIN) begin
         q = OMIN;
         clamped = 1'b1;
      end
      return int'(q);
   endfunction

   task automatic model_step(input bit r_rst, input bit v, input int y, input bit r);
      bit rd;
      bit wr;
      bit cl;
      longint s;
      if (r_rst) begin
         grp.delete();
         fq.delete();
         pend_v = 1'b0;
         x_sat  = 1'b0;
         x_ovf  = 1'b0;
      end else begin
         rd = (fq.size() > 0) && r;
         wr = pend_v && ((fq.size() < DEPTH) || rd);
         if (pend_v && !wr) x_ovf = 1'b1;
         if (rd) void'(fq.pop_front());
         if (wr) fq.push_back(pend);
         pend_v = 1'b0;
         x_sat  = 1'b0;
         if (v) begin
            grp.push_back(y);
            if (grp.size() == DECIM) begin
               s = 0;
               foreach (grp[i]) s += grp[i];
               pend   = avg_sat(s, cl);
               pend_v = 1'b1;
               x_sat  = cl;
               grp.delete();
            end
         end
      end
   endtask

   task automatic tick(input bit r_rst, input bit v, input int y, input bit r);
      rst     = r_rst;
      y_valid = v;
      y_in    = IN_W'(y);
      m_ready = r;
      @(posedge clk);
      model_step(r_rst, v, y, r);
      #1;
      chk("m_valid", m_valid, int'(fq.size() > 0));
      chk("fill", fill, fq.size());
      chk("m_data", $signed(m_data), (fq.size() > 0) ? fq[0] : 0);
      chk("sat", sat, int'(x_sat));
      chk("ovf", ovf, int'(x_ovf));
   endtask

   initial begin
      bit rr;
      bit v;
      bit r;
      int y;
      int thr;

      vt[0] = '{'{30, 0, 0, 0},         EXP_30, 1'b0};
      vt[1] = '{'{100, 100, 100, 100},  100,    1'b0};
      vt[2] = '{'{1000, 1000, 1000, 1000}, 127, 1'b1};
      vt[3] = '{'{-1000, -1000, -1000, -1000}, -128, 1'b1};
      vt[4] = '{'{-6, 0, 0, 0},         EXP_M6, 1'b0};

      // reset state
      tick(1, 0, 0, 1);
      chk("rst_valid", m_valid, 0);
      chk("rst_fill", fill, 0);
      chk("rst_data", $signed(m_data), 0);
      chk("rst_sat", sat, 0);
      chk("rst_ovf", ovf, 0);

      // directed group table: 2-edge latency from last sample to m_valid
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 4; j++) tick(0, 1, vt[i].s[j], 1);
         chk("vec_sat", sat, int'(vt[i].exp_sat));
         chk("vec_early_valid", m_valid, 0);
         tick(0, 0, 0, 1);
         chk("vec_valid", m_valid, 1);
         chk("vec_data", $signed(m_data), vt[i].exp_data);
         chk("vec_sat_pulse_end", sat, 0);
         tick(0, 0, 0, 1);
         chk("vec_drained", m_valid, 0);
      end

      // gaps in y_valid: samples on every other cycle
      for (int c = 0; c < 6; c++) tick(0, (c % 2) == 0, 20, 1);
      chk("gap_no_out_after_3", m_valid, 0);
      chk("gap_fill_after_3", fill, 0);
      tick(0, 1, 20, 1);
      tick(0, 0, 20, 1);
      chk("gap_valid", m_valid, 1);
      chk("gap_data", $signed(m_data), 20);
      tick(0, 0, 0, 1);
      chk("gap_drained", m_valid, 0);

      // overflow: 9 groups into an 8-deep FIFO with no reads
      for (int n = 1; n <= 9; n++)
         for (int j = 0; j < 4; j++) tick(0, 1, n, 0);
      tick(0, 0, 0, 0);
      chk("full_fill", fill, 8);
      chk("full_ovf", ovf, 1);
      for (int n = 1; n <= 8; n++) begin
         chk("drain_valid", m_valid, 1);
         chk("drain_data", $signed(m_data), n);
         tick(0, 0, 0, 1);
      end
      chk("drain_empty", m_valid, 0);
      chk("drain_fill", fill, 0);
      chk("drain_ovf_sticky", ovf, 1);

      // full FIFO with simultaneous read and write
      for (int n = 11; n <= 18; n++)
         for (int j = 0; j < 4; j++) tick(0, 1, n, 0);
      tick(0, 0, 0, 0);
      chk("rw_prefill", fill, 8);
      for (int j = 0; j < 4; j++) tick(0, 1, 19, 0);
      tick(0, 0, 0, 1);
      chk("rw_fill", fill, 8);
      chk("rw_head", $signed(m_data), 12);
      chk("rw_ovf", ovf, 1);
      for (int n = 12; n <= 19; n++) begin
         chk("rw_drain_data", $signed(m_data), n);
         tick(0, 0, 0, 1);
      end
      chk("rw_drain_empty", m_valid, 0);

      // reset in the middle of a group discards the partial sum
      tick(0, 1, 50, 1);
      tick(0, 1, 50, 1);
      tick(1, 1, 50, 1);
      chk("midrst_fill", fill, 0);
      chk("midrst_ovf", ovf, 0);
      chk("midrst_valid", m_valid, 0);
      for (int j = 0; j < 4; j++) tick(0, 1, 10, 1);
      chk("midrst_early", m_valid, 0);
      tick(0, 0, 0, 1);
      chk("midrst_valid_out", m_valid, 1);
      chk("midrst_data", $signed(m_data), 10);
      tick(0, 0, 0, 1);
      chk("midrst_after_valid", m_valid, 0);
      chk("midrst_after_ovf", ovf, 0);

      // randomized traffic against the reference model
      for (int c = 0; c < 1600; c++) begin
         thr = ((c / 200) % 2 == 1) ? 8 : 70;
         rr  = ($urandom_range(0, 199) == 0);
         v   = ($urandom_range(0, 99) < 75);
         r   = ($urandom_range(0, 99) < thr);
         case ($urandom_range(0, 3))
            0:       y = int'($urandom_range(0, 400)) - 200;
            1:       y = int'($signed(16'($urandom)));
            2:       y = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            default: y = int'($urandom_range(0, 1100)) - 550;
         endcase
         tick(rr, v, y, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
Downstream stage of fir_filter. Consumes the signed 16-bit filter output stream and decimates it by 2^DECIM_LOG2 using boxcar averaging (sum, then arithmetic shift). Saturates each averaged sample to OUT_W bits and buffers it in a small FIFO with a valid/ready output handshake for the next consumer.

Parameters:
IN_W, 16, width of signed input sample (matches fir_filter y_out)
OUT_W, 8, width of signed decimated output sample
DECIM_LOG2, 2, log2 of decimation factor (DECIM = 4); legal range 0..4
DEPTH_LOG2, 3, log2 of FIFO depth (8 entries)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
y_in  input  IN_W  signed sample from fir_filter
y_valid  input  1  y_in qualifier; sample is accepted on any edge where it is high (no backpressure upstream)
m_data  output  OUT_W  signed decimated sample at FIFO head
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data when m_valid && m_ready
fill  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2
sat  output  1  one-cycle pulse: the result register holds a saturated value
ovf  output  1  sticky: a result was dropped because the FIFO was full; cleared only by rst

Behaviour:
- Reset: synchronous, active-high. Clears acc, phase counter, result register, FIFO pointers and fill. m_valid=0, m_data=0, fill=0, sat=0, ovf=0 from the first edge with rst high. Reset mid-group discards the partial sum.
- Accumulator: ACC_W = IN_W+DECIM_LOG2 bits, signed; y_in is sign-extended. Wrap is impossible.
- Phase counter: 0..DECIM-1; advances only on y_valid. Gaps in y_valid hold acc and phase unchanged.
- On y_valid with phase<DECIM-1: acc <= acc + y_in; phase++.
- On y_valid with phase==DECIM-1: sum = acc + y_in. q = sum >>> DECIM_LOG2 (arithmetic shift). Then acc <= 0 and phase <= 0.
- Saturation: if q > 2^(OUT_W-1)-1, force q to that maximum. If q < -2^(OUT_W-1), force q to that minimum. sat is asserted in the cycle the saturated value sits in the result register.
- Result register (res, res_v): loaded on the same edge as the final sample of a group. res_v stays high for exactly one cycle.
- FIFO write: occurs on the edge after res_v is high, if not full.
  - If the FIFO is full and no read occurs on that edge, the result is dropped and ovf is set.
  - Full, with a simultaneous read: the write is accepted and fill is unchanged.
- FIFO read: occurs on an edge with m_valid && m_ready. m_data is combinational from the head entry (registered storage). Entries leave in write order.
- Empty FIFO with simultaneous write: no read occurs; m_valid rises after that edge. There is no fall-through.
- Latency:
  - Final sample of a group is accepted at edge k. res_v is high after edge k; the FIFO write happens at edge k+1; m_valid is high after edge k+1.
  - So m_valid rises 2 edges after the final sample, when the FIFO was empty.
- Throughput: sustains one input per cycle. Output rate is at most 1/DECIM.
- fill: incremented on write only, decremented on read only, unchanged when both occur.
- DECIM_LOG2=0: pass-through with saturation only. The rounding term is 0.

Optional Feature:
Macro FIR_DECIM_ROUND_EN.
- Defined: round half-up before the shift. q = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, computed in ACC_W+1 bits so the rounding add cannot wrap.
- Undefined: truncation toward minus infinity (plain arithmetic shift).
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Rounding: y_in 30,0,0,0 with y_valid continuous, m_ready=1 -> m_data=8 with FIR_DECIM_ROUND_EN, 7 without. m_valid high after 2nd edge following the 4th sample.
- Step and saturation:
  - 100 x4 -> m_data=100, sat=0.
  - Then 1000 x4 -> m_data=127, sat pulses 1 cycle.
  - Then -1000 x4 -> m_data=-128, sat pulses.
- Negative rounding: -6,0,0,0 -> m_data=-1 with rounding, -2 without.
- Valid gaps: y_valid high every other cycle with y_in=20 for 8 cycles (4 samples) -> exactly one output, 20. No output after only 3 valid samples.
- FIFO full/overflow:
  - m_ready=0; feed 9 groups with values 1..9 (each sample = n) -> fill=8, ovf=1, value 9 dropped.
  - Then m_ready=1 -> m_data 1..8 on 8 consecutive cycles, then m_valid=0, fill=0. ovf stays 1.
  - Full with simultaneous read+write -> fill stays 8, ovf unchanged.
- Reset mid-group: 2 samples of 50, assert rst 1 cycle, then 10 x4 -> single output 10. fill, ovf and m_valid are 0 during and after reset.
